pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Sits directly downstream of the board PLL. It sequences the PLL's RST input and consumes its asynchronous LOCK output. It releases the system reset only after lock has been held continuously for a qualification window. The block runs on the 25 MHz board reference clock, so it keeps running while the PLL output is stopped; sys_reset is re-synchronized into the PLL clock domain by the consumer.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per PLL reset attempt (min 1)
LOCK_TIMEOUT, 25000, cycles to wait for lock after pll_rst drops before retrying (1 ms @ 25 MHz)
STABLE_CYCLES, 2500, cycles locked_s must stay high before sys_reset releases (100 us)
MAX_RETRIES, 4, consecutive timeouts before retry_fail sets
SYNC_STAGES, 2, flip-flop stages on pll_locked (min 2)

Ports:
clk  in  1  25 MHz board reference clock
reset  in  1  synchronous, active-high
pll_locked  in  1  PLL LOCK, asynchronous to clk
pll_rst  out  1  drives PLL RST, registered
sys_reset  out  1  system reset, active-high, registered
ready  out  1  high only in RUN
retry_fail  out  1  sticky: MAX_RETRIES consecutive lock timeouts occurred
lock_loss_count  out  8  saturating count of lock losses seen in RUN
state  out  2  current FSM state encoding (debug)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high, named reset.
- Reset values: state=PLL_RST, counter=0, retry_cnt=0, pll_rst=1, sys_reset=1, ready=0, retry_fail=0, lock_loss_count=0, sync chain=0.
- Input sync: pll_locked passes through SYNC_STAGES FFs to give locked_s. Every reference to lock below means locked_s.
- One shared counter; it is cleared on every state transition.
- All outputs are registered and reflect the state entered at that edge.
- PLL_RST (enc 0):
  - pll_rst=1, sys_reset=1.
  - After exactly RST_CYCLES cycles in this state -> WAIT_LOCK.
- WAIT_LOCK (enc 1):
  - pll_rst=0, sys_reset=1.
  - locked_s=1 -> STABLE.
  - Otherwise, once counter reaches LOCK_TIMEOUT-1 -> PLL_RST. retry_cnt increments, saturating at MAX_RETRIES.
  - retry_cnt==MAX_RETRIES sets retry_fail. Retries continue indefinitely.
- STABLE (enc 2):
  - pll_rst=0, sys_reset=1.
  - locked_s=0 on any cycle -> WAIT_LOCK, with the timeout restarted from 0. This does not count as a retry.
  - locked_s=1 with counter at STABLE_CYCLES-1 -> RUN.
  - If locked_s drops on that same final cycle, the drop wins -> WAIT_LOCK.
- RUN (enc 3):
  - pll_rst=0, sys_reset=0, ready=1. retry_cnt clears on entry.
  - locked_s=0 -> PLL_RST. sys_reset and pll_rst go high at the same edge. lock_loss_count increments, saturating at 255.
- Latency:
  - From the first clk edge sampling pll_locked=1 (held), sys_reset falls SYNC_STAGES+1+STABLE_CYCLES edges later.
  - From a lock drop in RUN, sys_reset rises SYNC_STAGES+1 edges later.
- retry_fail clears only on reset. lock_loss_count never wraps.
- Reset asserted mid-operation (any state): all state, counters and outputs return to reset values on the next edge.
- Counter width: $clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state encodings PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3 and a 2-bit state type;
  - the 8-bit lock_loss_count width constant.
- One sub-module, bit_synchronizer:
  - parameter STAGES;
  - ports clk, reset, d, q;
  - reused by the consumer to bring sys_reset into the PLL clock domain.

Test Plan:
All tests use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
1. Clean start: release reset, raise pll_locked 10 cycles after pll_rst falls and hold it -> pll_rst high exactly 4 cycles; sys_reset falls 11 edges after pll_locked is first sampled high; ready=1; lock_loss_count=0.
2. Glitch during qualification: pll_locked high 5 cycles, low 1, then high -> return to WAIT_LOCK with no retry counted; sys_reset stays high until 8 further continuous locked cycles pass.
3. Timeouts: hold pll_locked=0 -> pll_rst re-pulses (4 cycles) every 24 cycles; retry_fail=1 after the second timeout; lock then succeeds -> RUN with retry_fail still 1.
4. Lock loss in RUN: drop pll_locked once in RUN -> sys_reset=1 and pll_rst=1 three edges after the drop; lock_loss_count=1; normal re-sequence follows.
5. Saturation: 300 lock-loss/relock cycles -> lock_loss_count holds at 255.
6. Mid-operation reset: assert reset during STABLE and during RUN -> next edge shows pll_rst=1, sys_reset=1, ready=0, retry_fail=0, lock_loss_count=0, state=0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encodings and
// the width of the lock-loss counter.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int unsigned LOSS_CNT_W = 8;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Used on PLL LOCK here and by the consumer to move sys_reset into the PLL domain.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL RST, waits for a qualified LOCK, then releases the system reset.
// Retries on lock timeout and re-sequences whenever lock is lost in RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 25000,
  parameter int unsigned STABLE_CYCLES = 2500,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_reset,
  output logic                  ready,
  output logic                  retry_fail,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic [1:0]            state
);

  localparam int unsigned CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  seq_state_t         cur;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_next;
  logic               locked_s;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    retry_next = retry_cnt;
    if (retry_cnt != RETRY_W'(MAX_RETRIES)) begin
      retry_next = retry_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur             <= PLL_RST;
      cnt             <= '0;
      retry_cnt       <= '0;
      pll_rst         <= 1'b1;
      sys_reset       <= 1'b1;
      ready           <= 1'b0;
      retry_fail      <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      case (cur)
        PLL_RST: begin
          if (cnt == CNT_W'(RST_CYCLES - 1)) begin
            cur     <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            cur <= STABLE;
            cnt <= '0;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            cur       <= PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            retry_cnt <= retry_next;
            if (retry_next == RETRY_W'(MAX_RETRIES)) begin
              retry_fail <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          // A drop on the final qualification cycle still wins over RUN.
          if (!locked_s) begin
            cur <= WAIT_LOCK;
            cnt <= '0;
          end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            cur       <= RUN;
            cnt       <= '0;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
            retry_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            cur       <= PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            if (lock_loss_count != '1) begin
              lock_loss_count <= lock_loss_count + 1'b1;
            end
          end
        end
        default: begin
          cur       <= PLL_RST;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          sys_reset <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer using small timing
// parameters; expected latencies are hand-derived from the behaviour description.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       retry_fail;
  logic [7:0] lock_loss_count;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .SYNC_STAGES   (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .retry_fail      (retry_fail),
    .lock_loss_count (lock_loss_count),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sig(input int which);
    case (which)
      0:       return {1'b0, pll_rst};
      1:       return {1'b0, ready};
      2:       return {1'b0, sys_reset};
      default: return state;
    endcase
  endfunction

  // Number of edges until the selected signal shows val (the first edge counts as 1).
  task automatic wait_sig(input int which, input logic [1:0] val, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sig(which) !== val && n <= 200);
  endtask

  task automatic check_reset_values(input string ctx);
    chk({ctx, ".pll_rst"},    pll_rst, 1);
    chk({ctx, ".sys_reset"},  sys_reset, 1);
    chk({ctx, ".ready"},      ready, 0);
    chk({ctx, ".retry_fail"}, retry_fail, 0);
    chk({ctx, ".llc"},        lock_loss_count, 0);
    chk({ctx, ".state"},      state, 0);
  endtask

  initial begin
    int n;
    int bad;
    reset      = 1'b1;
    pll_locked = 1'b0;
    tick();
    tick();
    check_reset_values("por");

    // Clean start
    reset = 1'b0;
    wait_sig(0, 0, n);
    chk("t1.pll_rst_width", n, 4);
    chk("t1.state_wait", state, 1);
    repeat (9) tick();
    pll_locked = 1'b1;
    wait_sig(2, 0, n);
    chk("t1.release_latency", n, 11);
    chk("t1.ready", ready, 1);
    chk("t1.state_run", state, 3);
    chk("t1.pll_rst_low", pll_rst, 0);
    chk("t1.llc", lock_loss_count, 0);
    chk("t1.retry_fail", retry_fail, 0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    wait_sig(0, 1, n);
    chk("t4.loss_latency", n, 3);
    chk("t4.sys_reset", sys_reset, 1);
    chk("t4.ready", ready, 0);
    chk("t4.llc", lock_loss_count, 1);
    chk("t4.state", state, 0);
    pll_locked = 1'b1;
    wait_sig(1, 1, n);
    chk("t4.reseq_latency", n, 13);
    chk("t4.llc_hold", lock_loss_count, 1);

    // Glitch during qualification
    reset      = 1'b1;
    pll_locked = 1'b0;
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t2.state_wait", state, 1);
    pll_locked = 1'b1;
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick();
    chk("t2.state_stable", state, 2);
    tick();
    chk("t2.back_to_wait", state, 1);
    tick();
    chk("t2.restable", state, 2);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (sys_reset !== 1'b1) bad++;
    end
    chk("t2.sys_reset_held", bad, 0);
    tick();
    chk("t2.sys_reset_release", sys_reset, 0);
    chk("t2.ready", ready, 1);
    chk("t2.retry_fail", retry_fail, 0);

    // Lock timeouts and retry_fail
    reset      = 1'b1;
    pll_locked = 1'b0;
    tick();
    reset = 1'b0;
    wait_sig(0, 0, n);
    chk("t3.first_pulse", n, 4);
    wait_sig(0, 1, n);
    chk("t3.timeout1", n, 20);
    chk("t3.retry_fail_after1", retry_fail, 0);
    wait_sig(0, 0, n);
    chk("t3.repulse_width", n, 4);
    wait_sig(0, 1, n);
    chk("t3.timeout2", n, 20);
    chk("t3.retry_fail_after2", retry_fail, 1);
    pll_locked = 1'b1;
    wait_sig(1, 1, n);
    chk("t3.lock_after_retry", n, 13);
    chk("t3.retry_fail_sticky", retry_fail, 1);
    chk("t3.sys_reset", sys_reset, 0);

    // Lock-loss counter saturation
    bad = 0;
    for (int i = 1; i <= 300; i++) begin
      pll_locked = 1'b0;
      wait_sig(0, 1, n);
      if (n != 3) bad++;
      pll_locked = 1'b1;
      wait_sig(1, 1, n);
      if (n != 13) bad++;
      if (i == 254) chk("t5.llc_254", lock_loss_count, 254);
      if (i == 255) chk("t5.llc_255", lock_loss_count, 255);
    end
    chk("t5.cycle_timing", bad, 0);
    chk("t5.llc_saturated", lock_loss_count, 255);
    chk("t5.retry_fail_kept", retry_fail, 1);

    // Mid-operation reset from RUN, then from STABLE
    reset = 1'b1;
    tick();
    check_reset_values("t6.run");
    reset = 1'b0;
    wait_sig(3, 2, n);
    chk("t6.reach_stable", n, 5);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_values("t6.stable");
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
